vga_frame_tx: RTL

//  Transmit side of the 28x28 image path. Reads the stored 28x28 8-bit image

---
 rtl/vga_frame_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_tx.sv
// Streams a stored IMG_DIM x IMG_DIM 8-bit image as a 640x480@60 VGA pixel stream.
// The image is upscaled by 2^SCALE_LOG2 and centred on a background colour.
module vga_frame_tx #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_DIM    = 28,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned X_OFF      = 96,
  parameter int unsigned Y_OFF      = 16,
  parameter logic [7:0]  BG_VALUE   = 8'h00,
  localparam int unsigned ADDR_W    = 10,
  localparam int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start,
  output logic              running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned WIN     = IMG_DIM << SCALE_LOG2;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] X_BEG      = H_W'(X_OFF);
  localparam logic [H_W-1:0] X_END      = H_W'(X_OFF + WIN);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] Y_BEG      = V_W'(Y_OFF);
  localparam logic [V_W-1:0] Y_END      = V_W'(Y_OFF + WIN);
  localparam logic [V_W-1:0] V_MASK     = V_W'((1 << SCALE_LOG2) - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [H_W-1:0]      h_cnt, h_nxt;
  logic [V_W-1:0]      v_cnt, v_nxt, v_rel_c;
  logic [ADDR_W-1:0]   row_base, row_nxt, addr_c;
  logic                run_c, active_c, in_img_c, hs_c, vs_c, fs_c, rd_c;
  logic                s1_valid, s1_img, s1_hs, s1_vs, s1_fs;

  function automatic logic in_win(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return (h >= X_BEG) && (h < X_END) && (v >= Y_BEG) && (v < Y_END);
  endfunction

  // Next state: start on enable, stop only at the end of a complete frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (h_cnt == H_LAST && v_cnt == V_LAST && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan counters; row_base tracks y_img*IMG_DIM for the next line without a multiplier
  always_comb begin
    h_nxt   = '0;
    v_nxt   = '0;
    row_nxt = '0;
    v_rel_c = '0;
    if (state_q == RUN) begin
      h_nxt   = h_cnt + H_W'(1);
      v_nxt   = v_cnt;
      row_nxt = row_base;
      if (h_cnt == H_LAST) begin
        h_nxt   = '0;
        v_nxt   = (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        v_rel_c = v_nxt - Y_BEG;
        if (v_nxt <= Y_BEG) row_nxt = '0;
        else if ((v_rel_c & V_MASK) == '0) row_nxt = row_base + ADDR_W'(IMG_DIM);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      running  <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
    end else begin
      state_q  <= state_d;
      running  <= (state_d == RUN);
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      row_base <= row_nxt;
    end
  end

  // Decode of the current position, plus a one-cycle look-ahead read so data lands in time
  always_comb begin
    run_c    = (state_q == RUN);
    active_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    in_img_c = in_win(h_cnt, v_cnt);
    hs_c     = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_c     = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
    rd_c     = (state_d == RUN) && in_win(h_nxt, v_nxt);
    addr_c   = row_nxt + ADDR_W'((h_nxt - X_BEG) >> SCALE_LOG2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_img    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_fs     <= 1'b0;
    end else begin
      mem_rd_en <= rd_c;
      if (rd_c) mem_addr <= addr_c;
      s1_valid  <= run_c && active_c;
      s1_img    <= run_c && in_img_c;
      s1_hs     <= !run_c || hs_c;
      s1_vs     <= !run_c || vs_c;
      s1_fs     <= run_c && fs_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_data    <= '0;
      vga_valid   <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_data    <= s1_valid ? (s1_img ? mem_rd_data : BG_VALUE) : '0;
      vga_valid   <= s1_valid;
      vga_hsync   <= s1_hs;
      vga_vsync   <= s1_vs;
      frame_start <= s1_fs;
    end
  end

endmodule
